btn_conditioner: RTL

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronises, debounces and classifies three raw push buttons.
// Each button produces a debounced level, a one-cycle press pulse on an accepted
// rising level and, when built with BTN_LONG_PRESS_EN, a one-cycle long-press pulse.
// Without BTN_LONG_PRESS_EN the hold counters and FSM are absent and btn_long is 0.
// Bit order on all vectors: bit0 = sw, bit1 = left, bit2 = right.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int LONG_PRESS_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_btn,
    input  logic       left_btn,
    input  logic       right_btn,
    output logic [2:0] btn_level,
    output logic [2:0] btn_press,
    output logic [2:0] btn_long
);

    localparam int unsigned NB = 3;
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES);

    if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_bad_params
        $error("btn_conditioner: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 1");
    end

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1_q, sync1_d;
    logic [NB-1:0] sync2_q, sync2_d;
    logic [NB-1:0] level_q, level_d;
    logic [NB-1:0] press_q, press_d;
    logic [DW-1:0] deb_cnt_q [NB];
    logic [DW-1:0] deb_cnt_d [NB];

    assign raw = {right_btn, left_btn, sw_btn};

    // Synchroniser shift, debounce counting and press-edge detection
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        level_d = level_q;
        for (int unsigned i = 0; i < NB; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            if (sync2_q[i] == level_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_MAX) begin
                level_d[i]   = ~level_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
        end
        press_d = level_d & ~level_q;
    end

    // Synchroniser, debounce and press registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            for (int unsigned i = 0; i < NB; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

`ifdef BTN_LONG_PRESS_EN
    localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 1);
    // The pulse is registered on the same edge the counter lands on LONG_PRESS_CYCLES.
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DOWN = 2'd1;
    localparam logic [1:0] ST_HELD = 2'd2;

    logic [1:0]    state_q [NB];
    logic [1:0]    state_d [NB];
    logic [HW-1:0] hold_q  [NB];
    logic [HW-1:0] hold_d  [NB];
    logic [NB-1:0] long_q, long_d;

    // Per-button press FSM; transitions follow the next debounced level
    always_comb begin
        long_d = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    if (level_d[i]) begin
                        state_d[i] = ST_DOWN;
                        hold_d[i]  = '0;
                    end
                end
                ST_DOWN: begin
                    if (!level_d[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (hold_q[i] == HOLD_LAST) begin
                        hold_d[i]  = hold_q[i] + HW'(1);
                        long_d[i]  = 1'b1;
                        state_d[i] = ST_HELD;
                    end else begin
                        hold_d[i] = hold_q[i] + HW'(1);
                    end
                end
                ST_HELD: begin
                    if (!level_d[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, hold counter and long-press pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            long_q <= '0;
            for (int unsigned i = 0; i < NB; i++) begin
                state_q[i] <= ST_IDLE;
                hold_q[i]  <= '0;
            end
        end else begin
            long_q <= long_d;
            for (int unsigned i = 0; i < NB; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
            end
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = '0;
`endif

endmodule
